// File: rtl/clarvi_alu_sequencer_pkg.sv
// Shared types for the byte-serial ALU sequencer.
// Holds the instr bundle, ALU op enum, FSM state and part-order helper.
package clarvi_alu_sequencer_pkg;

  localparam int SEQ_XLEN   = 64;
  localparam int SEQ_PART_W = 3;
  localparam int SEQ_NPARTS = 8;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic        is32_bit_op;
    logic        immediate_used;
    logic [2:0]  instr_part;
    logic [7:0]  immediate;
    logic [63:0] pc;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } alu_seq_state_t;

  function automatic logic is_shr(input alu_op_t op);
    return (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SL) || is_shr(op);
  endfunction

  // Compares and right shifts need the high bytes first;
  // word right shifts start at the top of the low word.
  function automatic logic [2:0] part_order(
    input alu_op_t    op,
    input logic       is32,
    input logic [2:0] step
  );
    logic       rev;
    logic       hw;
    logic [2:0] p;
    rev = (op == ALU_SLT) || (op == ALU_SLTU) ||
          (is_shr(op) && !is32);
    hw  = is_shr(op) && is32;
    unique case (1'b1)
      rev:     p = ~step;
      hw:      p = {step[2], ~step[1:0]};
      default: p = step;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/clarvi_alu_sequencer_part_order.sv
// Combinational step-to-part mapper for byte-serial sequencing.
// Shared by the ALU sequencer and byte-serial memory paths.
module clarvi_part_order
  import clarvi_alu_sequencer_pkg::*;
(
  input  alu_op_t    i_op,
  input  logic       i_is32,
  input  logic [2:0] i_step,
  output logic [2:0] o_part
);

  assign o_part = part_order(i_op, i_is32, i_step);

endmodule

// File: rtl/clarvi_alu_sequencer.sv
// Steps the 8-bit ALU through eight byte slices of a 64-bit op
// and reassembles the result for writeback.
module clarvi_alu_sequencer
  import clarvi_alu_sequencer_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PART_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  instr_t            in_instr,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              stall_in,
  input  logic              flush,
  output instr_t            alu_instr,
  output logic [7:0]        alu_rs1,
  output logic [7:0]        alu_rs2,
  output logic              alu_stall,
  input  logic [7:0]        alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [4:0]        out_rd
);

  alu_seq_state_t    r_state;
  logic [PART_W-1:0] r_step;
  instr_t            r_instr;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_result;

  logic [2:0]        w_part;
  logic [2:0]        w_bsel;
  logic              w_shift;

  clarvi_part_order u_order (
    .i_op   (r_instr.op),
    .i_is32 (r_instr.is32_bit_op),
    .i_step (r_step),
    .o_part (w_part)
  );

  // Shifts take their amount from byte 0 on every slice.
  assign w_shift = is_shift(r_instr.op);
  assign w_bsel  = w_shift ? 3'd0 : w_part;

  assign alu_rs1   = r_rs1[{w_part, 3'b000} +: 8];
  assign alu_rs2   = r_rs2[{w_bsel, 3'b000} +: 8];
  assign alu_stall = stall_in || (r_state != RUN);

  always_comb begin
    alu_instr            = r_instr;
    alu_instr.instr_part = w_part;
    alu_instr.immediate  = r_imm[{w_bsel, 3'b000} +: 8];
  end

  assign in_ready   = (r_state == IDLE) && !flush;
  assign out_valid  = (r_state == DONE);
  assign out_result = r_result;
  assign out_rd     = r_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_instr  <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_instr  <= in_instr;
            r_imm    <= in_imm;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_rd     <= in_rd;
            r_result <= '0;
            r_step   <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (!stall_in) begin
            r_result[{w_part, 3'b000} +: 8] <= alu_result;
            r_step <= r_step + 1'b1;
            if (&r_step) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clarvi_alu_sequencer.md
Name: clarvi_alu_sequencer

Overview:
Byte-serial operand sequencer and result collector that wraps the 8-bit ALU stage.
- Accepts one decoded instruction with full 64-bit operands, steps the ALU through eight instr_part slices in the op-specific order, and reassembles the eight result bytes.
- Presents one 64-bit result plus destination register to writeback through a valid/ready handshake.
- Sits between decode/register-read and writeback; the ALU instance is external and connected through the alu_* ports.

Parameters:
XLEN, 64, operand/result width; only 64 supported (8 parts of 8 bits).
PART_W, 3, width of instr_part / step counter.

Ports:
clock  in  1  core clock
reset  in  1  reset, asynchronous, active-low (0 = reset)
in_valid  in  1  decoded instruction available
in_ready  out  1  sequencer can accept this cycle
in_instr  in  instr_t  decoded instr (op, is32_bit_op, immediate_used, pc); instr_part/immediate fields ignored
in_imm  in  64  full sign-extended immediate
in_rs1  in  64  rs1 value
in_rs2  in  64  rs2 value
in_rd  in  5  destination register
stall_in  in  1  global pipeline stall
flush  in  1  abort current instruction
alu_instr  out  instr_t  per-slice instr to ALU (instr_part, 8-bit immediate slice filled)
alu_rs1  out  8  rs1 byte for current part
alu_rs2  out  8  rs2 byte for current part
alu_stall  out  1  freezes ALU carry/state
alu_result  in  8  ALU byte result (combinational, same cycle)
out_valid  out  1  result ready for writeback
out_ready  in  1  writeback accepts
out_result  out  64  assembled result
out_rd  out  5  destination register

Behaviour:
- States:
  - IDLE: in_ready = !flush.
  - RUN: step counter 0..7.
  - DONE: out_valid = 1.
- Reset (async, low): state IDLE, step 0, out_valid 0, out_result 0, out_rd 0, operand registers 0.
- Accept: in_valid && in_ready in IDLE latches instr, imm, rs1, rs2, rd, clears the result register, and enters RUN with step 0.
- RUN, each cycle with !stall_in:
  - present part = order(op, is32, step); capture alu_result into out_result byte[part] at the clock edge; step++.
  - after step 7 is captured, go to DONE.
- Part order:
  - 7,6,5,4,3,2,1,0 for SLT, SLTU, and 64-bit SRL/SRA.
  - 3,2,1,0,7,6,5,4 for 32-bit SRL/SRA.
  - 0..7 for all other ops.
- Operand bytes:
  - alu_rs1 = rs1 byte[part].
  - For SL/SRL/SRA, alu_rs2 and the immediate slice are always byte[0] (shift amount); otherwise rs2 byte[part] and imm byte[part].
  - alu_instr.pc = latched pc.
- alu_stall = stall_in || state != RUN, so ALU state only advances on real slices.
- stall_in in RUN: step, alu_instr and the captured result are held; no capture.
- DONE:
  - out_valid = 1 holds out_result and out_rd stable until out_ready.
  - on out_ready, go to IDLE the same edge.
  - no overlap: in_ready = 0 in DONE.
- Latency: accept at edge T; slices T+1..T+8 when unstalled; out_valid from T+9; each stall cycle adds one.
- flush:
  - highest priority after reset.
  - RUN or DONE: go to IDLE next edge; out_valid drops; nothing written back.
  - In IDLE, flush blocks acceptance.
  - flush overrides stall_in.
- Simultaneous out_ready and flush in DONE: IDLE, handshake treated as not completed.
- Reset mid-RUN: immediate IDLE; partial result discarded.

Decomposition:
- Shared package (riscv.svh): alu_seq_state_t enum {IDLE, RUN, DONE}; helper function part_order(op, is32, step) returning a 3-bit part. instr_t and the op enum are reused unchanged.
- One natural sub-module: clarvi_part_order, a combinational step-to-part mapper. It is tested standalone and reused by a future load/store byte sequencer.

Test Plan:
- ADD 64: rs1=0x00000000_FFFFFFFF, rs2=1 -> alu parts 0..7; out_result=0x00000001_00000000; out_valid at T+9.
- ADDW: rs1=0x7FFFFFFF, rs2=1 -> out_result=0xFFFFFFFF_80000000.
- SRA 64: rs1=0x80000000_00000000, rs2=4 -> parts 7..0; alu_rs2=0x04 every slice; out_result=0xF8000000_00000000.
- SRAW: rs1=0x00000000_80000000, imm=4 -> parts 3,2,1,0,7,6,5,4; out_result=0xFFFFFFFF_F8000000.
- SLT: rs1=0xFFFFFFFF_FFFFFFFF, rs2=0 -> parts 7..0; out_result=1. Repeat with SLTU -> 0.
- Stall/flush/backpressure:
  - stall_in high 3 cycles at step 2 -> alu_instr.instr_part held at 2; alu_stall=1; result unchanged; out_valid at T+12.
  - flush at step 5 -> IDLE next cycle; no out_valid.
  - out_ready low 4 cycles -> out_result stable and in_ready=0 throughout.
